// File: rtl/brg_cfg_ctrl_if.sv
// Bus bundle between the SPART control logic, the baud generator and brg_cfg_ctrl.
// Handshake: the host holds i_host_req (with i_host_hi/i_host_data stable) until it
// sees o_host_gnt high for one cycle; the write is issued to the generator in that
// same cycle, so the host drops or changes its request on the following cycle.
interface brg_cfg_ctrl_if;
  logic [1:0]  i_baud_sel;
  logic        i_auto_en;
  logic        i_host_req;
  logic        i_host_hi;
  logic [7:0]  i_host_data;
  logic        o_host_gnt;
  logic        i_rx_enable;
  logic        o_load_low;
  logic        o_load_high;
  logic [7:0]  o_data_out;
  logic [15:0] o_divisor;
  logic        o_busy;
  logic        o_brg_ok;
  logic        o_rate_err;
  logic [2:0]  o_state_dbg;

  modport slave (
    input  i_baud_sel, i_auto_en, i_host_req, i_host_hi, i_host_data, i_rx_enable,
    output o_host_gnt, o_load_low, o_load_high, o_data_out, o_divisor,
    output o_busy, o_brg_ok, o_rate_err, o_state_dbg
  );

  modport master (
    output i_baud_sel, i_auto_en, i_host_req, i_host_hi, i_host_data, i_rx_enable,
    input  o_host_gnt, o_load_low, o_load_high, o_data_out, o_divisor,
    input  o_busy, o_brg_ok, o_rate_err, o_state_dbg
  );
endinterface

// File: rtl/brg_cfg_ctrl.sv
// Divisor programming sequencer, host/sequencer arbiter for the generator's single
// load port, and rx_enable rate monitor for the SPART baud rate generator.
module brg_cfg_ctrl #(
  parameter logic [15:0] DIV0 = 16'h0516,
  parameter logic [15:0] DIV1 = 16'h028B,
  parameter logic [15:0] DIV2 = 16'h0146,
  parameter logic [15:0] DIV3 = 16'h00A3,
  parameter int unsigned TOL  = 2
) (
  input  logic           clk,
  input  logic           rst,
  brg_cfg_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_LOAD_LO   = 3'd1,
    ST_LOAD_HI   = 3'd2,
    ST_WAIT_SYNC = 3'd3,
    ST_MONITOR   = 3'd4
  } state_t;

  function automatic logic [7:0] f_lo(input logic [1:0] sel);
    case (sel)
      2'd0:    f_lo = DIV0[7:0];
      2'd1:    f_lo = DIV1[7:0];
      2'd2:    f_lo = DIV2[7:0];
      default: f_lo = DIV3[7:0];
    endcase
  endfunction

  function automatic logic [7:0] f_hi(input logic [1:0] sel);
    case (sel)
      2'd0:    f_hi = DIV0[15:8];
      2'd1:    f_hi = DIV1[15:8];
      2'd2:    f_hi = DIV2[15:8];
      default: f_hi = DIV3[15:8];
    endcase
  endfunction

  state_t      r_state, w_state_nx;
  logic [1:0]  r_sync1, r_sync2;
  logic [1:0]  r_sel_q, w_sel_q_nx;
  logic        r_load_low, w_load_low_nx;
  logic        r_load_high, w_load_high_nx;
  logic [7:0]  r_data, w_data_nx;
  logic        r_gnt, w_gnt_nx;
  logic [15:0] r_div, w_div_nx;
  logic        r_rate_err, w_rate_err_nx;
  logic        r_seen, w_seen_nx;
  logic [17:0] r_cnt, w_cnt_nx;

  logic        w_auto, w_host_ok, w_do_load, w_do_grant, w_rate_bad, w_sat;
  logic [16:0] w_div_p1, w_dev;
  logic [17:0] w_limit, w_cnt_inc;

  assign w_auto    = bus.i_auto_en && (r_sync2 != r_sel_q);
  // A request still high during its own grant cycle is the one being served.
  assign w_host_ok = bus.i_host_req && !r_gnt;
  assign w_div_p1  = {1'b0, r_div} + 17'd1;
  assign w_limit   = {w_div_p1, 1'b0} + 18'd8;
  assign w_cnt_inc = r_cnt + 18'd1;
  assign w_dev     = (r_cnt[16:0] >= w_div_p1) ? (r_cnt[16:0] - w_div_p1)
                                               : (w_div_p1 - r_cnt[16:0]);
  assign w_rate_bad = (w_dev > 17'(TOL));
  assign w_sat      = (r_cnt[16:0] == 17'h1FFFF);

  // Two-flop synchronizer; left unreset so it tracks the switches while rst is held
  // and the first load after reset already sees the real selection.
  always_ff @(posedge clk) begin
    r_sync1 <= bus.i_baud_sel;
    r_sync2 <= r_sync1;
  end

  // Next-state and next-output decode; strobes/data are registered from these.
  always_comb begin
    w_state_nx     = r_state;
    w_sel_q_nx     = r_sel_q;
    w_load_low_nx  = 1'b0;
    w_load_high_nx = 1'b0;
    w_data_nx      = 8'h00;
    w_gnt_nx       = 1'b0;
    w_div_nx       = r_div;
    w_rate_err_nx  = r_rate_err;
    w_seen_nx      = r_seen;
    w_cnt_nx       = r_cnt;
    w_do_load      = 1'b0;
    w_do_grant     = 1'b0;
    case (r_state)
      ST_INIT: w_do_load = 1'b1;
      ST_LOAD_LO: begin
        w_state_nx     = ST_LOAD_HI;
        w_load_high_nx = 1'b1;
        w_data_nx      = f_hi(r_sel_q);
        w_div_nx[15:8] = f_hi(r_sel_q);
        w_rate_err_nx  = 1'b0;
        w_seen_nx      = 1'b0;
        w_cnt_nx       = '0;
      end
      ST_LOAD_HI: begin
        w_state_nx = ST_WAIT_SYNC;
        w_seen_nx  = 1'b0;
        w_cnt_nx   = '0;
        w_do_grant = w_host_ok;
      end
      ST_WAIT_SYNC: begin
        if (w_auto) begin
          w_do_load = 1'b1;
        end else if (w_host_ok) begin
          w_do_grant = 1'b1;
        end else if (w_cnt_inc == w_limit) begin
          w_rate_err_nx = 1'b1;
          w_state_nx    = ST_MONITOR;
          w_cnt_nx      = '0;
        end else begin
          w_cnt_nx = w_cnt_inc;
          // First pulse may be a mid-countdown fire of the old period; skip it.
          if (bus.i_rx_enable) begin
            if (r_seen) begin
              w_state_nx = ST_MONITOR;
              w_cnt_nx   = '0;
            end else begin
              w_seen_nx = 1'b1;
            end
          end
        end
      end
      ST_MONITOR: begin
        if (w_auto) begin
          w_do_load = 1'b1;
        end else if (w_host_ok) begin
          w_do_grant = 1'b1;
        end else if (bus.i_rx_enable) begin
          if (w_rate_bad) w_rate_err_nx = 1'b1;
          w_cnt_nx = 18'd1;
        end else if (w_sat) begin
          w_rate_err_nx = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      default: w_state_nx = ST_INIT;
    endcase
    if (w_do_load) begin
      w_state_nx    = ST_LOAD_LO;
      w_load_low_nx = 1'b1;
      w_data_nx     = f_lo(r_sync2);
      w_sel_q_nx    = r_sync2;
      w_div_nx[7:0] = f_lo(r_sync2);
    end
    if (w_do_grant) begin
      w_state_nx    = ST_WAIT_SYNC;
      w_gnt_nx      = 1'b1;
      w_data_nx     = bus.i_host_data;
      w_rate_err_nx = 1'b0;
      w_seen_nx     = 1'b0;
      w_cnt_nx      = '0;
      if (bus.i_host_hi) begin
        w_load_high_nx = 1'b1;
        w_div_nx[15:8] = bus.i_host_data;
      end else begin
        w_load_low_nx  = 1'b1;
        w_div_nx[7:0]  = bus.i_host_data;
      end
    end
  end

  // State and registered outputs; rst aborts any state immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_sel_q     <= 2'b01;
      r_load_low  <= 1'b0;
      r_load_high <= 1'b0;
      r_data      <= 8'h00;
      r_gnt       <= 1'b0;
      r_div       <= DIV1;
      r_rate_err  <= 1'b0;
      r_seen      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_sel_q     <= w_sel_q_nx;
      r_load_low  <= w_load_low_nx;
      r_load_high <= w_load_high_nx;
      r_data      <= w_data_nx;
      r_gnt       <= w_gnt_nx;
      r_div       <= w_div_nx;
      r_rate_err  <= w_rate_err_nx;
      r_seen      <= w_seen_nx;
      r_cnt       <= w_cnt_nx;
    end
  end

  assign bus.o_load_low  = r_load_low;
  assign bus.o_load_high = r_load_high;
  assign bus.o_data_out  = r_data;
  assign bus.o_host_gnt  = r_gnt;
  assign bus.o_divisor   = r_div;
  assign bus.o_rate_err  = r_rate_err;
  assign bus.o_busy      = (r_state != ST_MONITOR);
  assign bus.o_brg_ok    = (r_state == ST_MONITOR) && !r_rate_err;
  assign bus.o_state_dbg = r_state;

endmodule

// File: doc/brg_cfg_ctrl.md
Name: brg_cfg_ctrl

Overview:
Configuration sequencer and bus arbiter for the SPART baud rate generator.
- Programs the 16-bit divisor (DBL, then DBH) from a baud-select table after reset and whenever the synchronized baud select changes.
- Shares the generator's single load/data port with a host writer.
- Monitors the generator's rx_enable pulse spacing against the programmed divisor and flags rate errors.
- Sits between the top-level SPART control/switch logic and the baud rate generator.

Parameters:
- DIV0, 16'h0516, divisor for baud_sel=00 (4800 baud at 100 MHz, x16 oversample).
- DIV1, 16'h028B, divisor for baud_sel=01 (9600).
- DIV2, 16'h0146, divisor for baud_sel=10 (19200).
- DIV3, 16'h00A3, divisor for baud_sel=11 (38400).
- TOL, 2, allowed absolute deviation, in clk cycles, of the measured rx_enable interval from divisor+1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- baud_sel  in  2  asynchronous switch input selecting DIV0..DIV3.
- auto_en  in  1  1 = reprogram on baud_sel change; 0 = ignore baud_sel changes after the initial load.
- host_req  in  1  host write request; held until host_gnt.
- host_hi  in  1  host target byte: 1 = DBH, 0 = DBL.
- host_data  in  8  host write data.
- host_gnt  out  1  one-cycle grant; the write is issued in the same cycle.
- rx_enable  in  1  rx tick from the generator.
- load_low  out  1  DBL load strobe to the generator.
- load_high  out  1  DBH load strobe to the generator.
- data_out  out  8  data bus to the generator.
- divisor  out  16  shadow of the currently programmed {DBH,DBL}.
- busy  out  1  high in every state except MONITOR.
- brg_ok  out  1  high only in MONITOR with rate_err=0.
- rate_err  out  1  sticky interval/timeout error.

Behaviour:
Reset:
- rst is asynchronous, active-high; clock is clk.
- Reset values: all outputs 0, except divisor = DIV1 and busy = 1.
- FSM enters LOAD_LO on the first clk after rst deasserts.
- Assertion of rst in any state aborts that state immediately.

Inputs and outputs:
- baud_sel passes through a 2-flop synchronizer; sel_q holds the last applied value.
- All strobes and data_out are registered.
- load_low and load_high are never asserted in the same cycle.
- data_out = 0 whenever neither strobe is asserted.

FSM states:
- LOAD_LO (1 cycle): load_low=1, data_out=table[sel_sync][7:0]; sel_q<=sel_sync; divisor[7:0] updated.
- LOAD_HI (1 cycle): load_high=1, data_out=table[sel_q][15:8]; divisor[15:8] updated; clear rate_err, pulse count and interval counter; go to WAIT_SYNC.
- WAIT_SYNC:
  - Discard the first rx_enable pulse, because the generator's comparator can fire mid-countdown on a new period.
  - On the second pulse, clear the interval counter and go to MONITOR.
  - Timeout: if the cycles since entry reach 2*(divisor+1)+8 (18-bit compare) before the second pulse, set rate_err and go to MONITOR.
- MONITOR:
  - The 17-bit interval counter increments every cycle and saturates at 17'h1FFFF.
  - On each rx_enable: if |count - (divisor+1)| > TOL, set rate_err; then reset count to 1.
  - Saturation also sets rate_err.

Host arbitration:
- Host writes are granted only in WAIT_SYNC or MONITOR, one per cycle.
- In the grant cycle: host_gnt=1, the matching strobe is driven with host_data, the divisor shadow byte is updated, and the FSM goes to WAIT_SYNC with rate_err cleared.
- While in LOAD_LO/LOAD_HI, host_req waits; it is not dropped.

Auto reprogram:
- Trigger: auto_en=1 and sel_sync != sel_q in WAIT_SYNC or MONITOR.
- Result: go to LOAD_LO. This takes priority over a simultaneous host_req, which is granted after the sequence.

Simultaneous events:
- If the rx_enable pulse coincides with a grant or auto reprogram, the reprogram/grant wins and the pulse is not measured.

Test Plan:
1. Release rst with baud_sel=01:
   - cycle 1: load_low=1, data_out=8B;
   - cycle 2: load_high=1, data_out=02;
   - divisor=028B, busy=1;
   - model brg pulses every 652 cycles → brg_ok=1 after the second pulse, rate_err stays 0.
2. In MONITOR, switch baud_sel 01→11 with auto_en=1:
   - the strobe pair reaches the generator within 4 cycles with data A3 then 00;
   - divisor=00A3;
   - monitoring resumes on 164-cycle spacing.
3. Same switch with auto_en=0: no strobes, divisor stays 028B.
4. host_req, host_hi=0, data 55 during LOAD_HI:
   - grant is deferred to the first WAIT_SYNC cycle;
   - in that cycle host_gnt=1, load_low=1, data_out=55, divisor[7:0]=55.
5. In MONITOR, pulses spaced 660 cycles with divisor 028B (deviation 8 > TOL=2): rate_err=1 and brg_ok=0; both hold until the next reprogram.
6. No rx_enable after programming 028B: rate_err rises at cycle 1312 of WAIT_SYNC and the FSM enters MONITOR; asserting rst mid-LOAD_HI clears all outputs immediately.
